dot_square_mover: RTL and testbench

Per-frame coordinate generator for the rectangle drawing stage: it owns the rectangle's top-left position and direction, and moves the rectangle by a programmable step on selected frame-start pulses. It bounces the rectangle off the display edges and drives the Dxs/Dxe/Dys/Dye bounds consumed by the rectangle pixel generator. Bounds change only at frame boundaries, so a rectangle never tears mid-frame. It sits in the VTUnit pixel path, directly upstream of the square generator.

---
 rtl/dot_square_mover_pkg.sv | 38 +++
 rtl/dot_axis_bounce.sv | 57 +++++
 rtl/dot_square_mover.sv | 148 ++++++++++++++
 tb/tb_dot_square_mover.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dot_square_mover_pkg.sv
// Shared VT definitions for the moving-rectangle coordinate generator.
package dot_square_mover_pkg;

  // Frame-update FSM encoding.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCalc   = 2'd1,
    StCommit = 2'd2
  } state_e;

  // Direction encoding: 0 moves toward larger coordinates.
  localparam logic DirPos = 1'b0;
  localparam logic DirNeg = 1'b1;

  localparam int unsigned DefHdisplay = 640;
  localparam int unsigned DefVdisplay = 480;

  // Position after a load: keep the whole rectangle on screen, 0 when it cannot fit.
  function automatic int unsigned clamp_load(input int unsigned init, input int unsigned size,
                                             input int unsigned limit);
    if (size >= limit) begin
      return 0;
    end else if (init > limit - size) begin
      return limit - size;
    end
    return init;
  endfunction

  // Exclusive end coordinate, clipped to the display edge.
  function automatic int unsigned clamp_end(input int unsigned pos, input int unsigned size,
                                            input int unsigned limit);
    if (pos + size >= limit) begin
      return limit;
    end
    return pos + size;
  endfunction

endpackage

// File: rtl/dot_axis_bounce.sv
// One axis of the mover: step, bounce off either edge, clamp the end coordinate.
module dot_axis_bounce
  import dot_square_mover_pkg::*;
#(
  parameter int unsigned Width     = 11,
  parameter int unsigned StepWidth = 4
) (
  input  logic [Width-1:0]     pos,
  input  logic                 dir,
  input  logic [StepWidth-1:0] step,
  input  logic [Width-1:0]     size,
  input  logic [Width-1:0]     limit,
  output logic [Width-1:0]     next_pos,
  output logic                 next_dir,
  output logic [Width-1:0]     end_coord
);

  // Two spare bits so pos + step + size can never wrap.
  localparam int unsigned Ext = Width + 2;

  logic [Ext-1:0] pos_e, step_e, size_e, limit_e, adv, reach, end_e;

  assign pos_e   = Ext'(pos);
  assign step_e  = Ext'(step);
  assign size_e  = Ext'(size);
  assign limit_e = Ext'(limit);
  assign adv     = pos_e + step_e;
  assign reach   = adv + size_e;

  // Next position and direction for one move.
  always_comb begin
    next_pos = pos;
    next_dir = dir;
    if (size_e >= limit_e) begin
      // Oversize rectangle pins to the origin and keeps its direction.
      next_pos = '0;
    end else if (dir == DirPos) begin
      if (reach >= limit_e) begin
        next_pos = Width'(limit_e - size_e);
        next_dir = DirNeg;
      end else begin
        next_pos = Width'(adv);
      end
    end else begin
      if (pos_e <= step_e) begin
        next_pos = '0;
        next_dir = DirPos;
      end else begin
        next_pos = Width'(pos_e - step_e);
      end
    end
  end

  assign end_e     = Ext'(next_pos) + size_e;
  assign end_coord = (end_e >= limit_e) ? limit : Width'(end_e);

endmodule

// File: rtl/dot_square_mover.sv
// Per-frame rectangle position generator with edge bounce and frame-aligned bound updates.
module dot_square_mover
  import dot_square_mover_pkg::*;
#(
  parameter int unsigned pHdisplayWidth = 11,
  parameter int unsigned pVdisplayWidth = 11,
  parameter int unsigned pHdisplay      = DefHdisplay,
  parameter int unsigned pVdisplay      = DefVdisplay,
  parameter int unsigned pStepWidth     = 4
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iFrameStart,
  input  logic                      iEnable,
  input  logic                      iLoad,
  input  logic [pHdisplayWidth-1:0] iInitX,
  input  logic [pVdisplayWidth-1:0] iInitY,
  input  logic [pHdisplayWidth-1:0] iSizeX,
  input  logic [pVdisplayWidth-1:0] iSizeY,
  input  logic [pStepWidth-1:0]     iStepX,
  input  logic [pStepWidth-1:0]     iStepY,
  input  logic [3:0]                iFrameDiv,
  output logic [pHdisplayWidth-1:0] oDxs,
  output logic [pHdisplayWidth-1:0] oDxe,
  output logic [pVdisplayWidth-1:0] oDys,
  output logic [pVdisplayWidth-1:0] oDye,
  output logic                      oDirX,
  output logic                      oDirY,
  output logic                      oUpdate,
  output logic                      oOverrun
);

  localparam logic [pHdisplayWidth-1:0] HLimit = pHdisplayWidth'(pHdisplay);
  localparam logic [pVdisplayWidth-1:0] VLimit = pVdisplayWidth'(pVdisplay);

  state_e                    state;
  logic [3:0]                frame_cnt;
  logic [pHdisplayWidth-1:0] pos_x, sh_x, sh_xe, nx_x, nx_xe, load_x, load_xe;
  logic [pVdisplayWidth-1:0] pos_y, sh_y, sh_ye, nx_y, nx_ye, load_y, load_ye;
  logic                      sh_dir_x, sh_dir_y, nx_dir_x, nx_dir_y;

  dot_axis_bounce #(
    .Width    (pHdisplayWidth),
    .StepWidth(pStepWidth)
  ) u_axis_x (
    .pos      (pos_x),
    .dir      (oDirX),
    .step     (iStepX),
    .size     (iSizeX),
    .limit    (HLimit),
    .next_pos (nx_x),
    .next_dir (nx_dir_x),
    .end_coord(nx_xe)
  );

  dot_axis_bounce #(
    .Width    (pVdisplayWidth),
    .StepWidth(pStepWidth)
  ) u_axis_y (
    .pos      (pos_y),
    .dir      (oDirY),
    .step     (iStepY),
    .size     (iSizeY),
    .limit    (VLimit),
    .next_pos (nx_y),
    .next_dir (nx_dir_y),
    .end_coord(nx_ye)
  );

  assign load_x  = pHdisplayWidth'(clamp_load(32'(iInitX), 32'(iSizeX), pHdisplay));
  assign load_xe = pHdisplayWidth'(clamp_end(32'(load_x), 32'(iSizeX), pHdisplay));
  assign load_y  = pVdisplayWidth'(clamp_load(32'(iInitY), 32'(iSizeY), pVdisplay));
  assign load_ye = pVdisplayWidth'(clamp_end(32'(load_y), 32'(iSizeY), pVdisplay));

  // The left/top bound is the position register itself.
  assign oDxs = pos_x;
  assign oDys = pos_y;

  // Frame FSM, divider, shadow registers and registered bounds; load outranks everything.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= StIdle;
      frame_cnt <= '0;
      pos_x     <= '0;
      pos_y     <= '0;
      oDxe      <= '0;
      oDye      <= '0;
      oDirX     <= DirPos;
      oDirY     <= DirPos;
      sh_x      <= '0;
      sh_xe     <= '0;
      sh_y      <= '0;
      sh_ye     <= '0;
      sh_dir_x  <= DirPos;
      sh_dir_y  <= DirPos;
      oUpdate   <= 1'b0;
      oOverrun  <= 1'b0;
    end else if (iLoad) begin
      // A frame pulse coinciding with a load is dropped without flagging overrun.
      state     <= StIdle;
      frame_cnt <= '0;
      pos_x     <= load_x;
      pos_y     <= load_y;
      oDxe      <= load_xe;
      oDye      <= load_ye;
      oDirX     <= DirPos;
      oDirY     <= DirPos;
      oUpdate   <= 1'b1;
    end else begin
      oUpdate <= 1'b0;
      unique case (state)
        StIdle: begin
          if (iFrameStart) begin
            if (iEnable && (frame_cnt == iFrameDiv)) begin
              state     <= StCalc;
              frame_cnt <= '0;
            end else if (frame_cnt != 4'hF) begin
              frame_cnt <= frame_cnt + 4'd1;
            end
          end
        end
        StCalc: begin
          sh_x     <= nx_x;
          sh_xe    <= nx_xe;
          sh_dir_x <= nx_dir_x;
          sh_y     <= nx_y;
          sh_ye    <= nx_ye;
          sh_dir_y <= nx_dir_y;
          state    <= StCommit;
          if (iFrameStart) oOverrun <= 1'b1;
        end
        StCommit: begin
          pos_x   <= sh_x;
          oDxe    <= sh_xe;
          oDirX   <= sh_dir_x;
          pos_y   <= sh_y;
          oDye    <= sh_ye;
          oDirY   <= sh_dir_y;
          oUpdate <= 1'b1;
          state   <= StIdle;
          if (iFrameStart) oOverrun <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_square_mover.sv
// Directed bench for dot_square_mover: bounces, divider, overrun, load collision, oversize.
module tb_dot_square_mover;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic        enable;
  logic        load;
  logic [10:0] init_x, init_y, size_x, size_y;
  logic [3:0]  step_x, step_y, frame_div;
  logic [10:0] dxs, dxe, dys, dye;
  logic        dir_x, dir_y, update, overrun;

  int n_checks = 0;
  int n_fails  = 0;
  int upd_cnt  = 0;
  int base;

  dot_square_mover u_dut (
    .iClk       (clk),
    .iRst       (rst),
    .iFrameStart(frame_start),
    .iEnable    (enable),
    .iLoad      (load),
    .iInitX     (init_x),
    .iInitY     (init_y),
    .iSizeX     (size_x),
    .iSizeY     (size_y),
    .iStepX     (step_x),
    .iStepY     (step_y),
    .iFrameDiv  (frame_div),
    .oDxs       (dxs),
    .oDxe       (dxe),
    .oDys       (dys),
    .oDye       (dye),
    .oDirX      (dir_x),
    .oDirY      (dir_y),
    .oUpdate    (update),
    .oOverrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count update pulses seen at each rising edge.
  always @(posedge clk) if (update === 1'b1) upd_cnt <= upd_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic do_load(input logic [10:0] x, input logic [10:0] y);
    init_x = x;
    init_y = y;
    load   = 1'b1;
    tick(1);
    load   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; enable = 1'b0; load = 1'b0;
    init_x = '0; init_y = '0; size_x = 11'd32; size_y = 11'd16;
    step_x = 4'd8; step_y = 4'd4; frame_div = 4'd0;
    tick(3);
    rst = 1'b0;

    // Reset state, then frames with movement disabled.
    base = upd_cnt;
    pulse_frame(); tick(4);
    pulse_frame(); tick(4);
    check_eq("rst_dxs", 32'(dxs), 32'd0);
    check_eq("rst_dxe", 32'(dxe), 32'd0);
    check_eq("rst_dys", 32'(dys), 32'd0);
    check_eq("rst_dye", 32'(dye), 32'd0);
    check_eq("rst_no_update", 32'(upd_cnt - base), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);

    // Right-edge bounce: 600+8+32 reaches 640, so park at 608 and turn around.
    enable = 1'b1;
    do_load(11'd600, 11'd100);
    check_eq("load_upd", 32'(update), 32'd1);
    check_eq("load_dxs", 32'(dxs), 32'd600);
    check_eq("load_dxe", 32'(dxe), 32'd632);
    tick(2);
    pulse_frame();           // now in cycle n+1
    check_eq("calc_no_upd", 32'(update), 32'd0);
    tick(2);                 // cycle n+3
    check_eq("rb_upd", 32'(update), 32'd1);
    check_eq("rb_dxs", 32'(dxs), 32'd608);
    check_eq("rb_dxe", 32'(dxe), 32'd640);
    check_eq("rb_dirx", 32'(dir_x), 32'd1);
    check_eq("rb_dys", 32'(dys), 32'd104);
    check_eq("rb_dye", 32'(dye), 32'd120);
    check_eq("rb_diry", 32'(dir_y), 32'd0);
    tick(3);

    // Left-edge bounce: first park at x=5 heading left using a 635-wide zero-step move.
    size_x = 11'd635; step_x = 4'd0; step_y = 4'd0;
    do_load(11'd5, 11'd100);
    tick(2);
    pulse_frame(); tick(4);
    check_eq("lb_setup_dxs", 32'(dxs), 32'd5);
    check_eq("lb_setup_dirx", 32'(dir_x), 32'd1);
    size_x = 11'd32; step_x = 4'd8;
    pulse_frame(); tick(4);
    check_eq("lb_dxs", 32'(dxs), 32'd0);
    check_eq("lb_dxe", 32'(dxe), 32'd32);
    check_eq("lb_dirx", 32'(dir_x), 32'd0);
    pulse_frame(); tick(4);
    check_eq("lb_next_dxs", 32'(dxs), 32'd8);
    check_eq("lb_next_dxe", 32'(dxe), 32'd40);

    // Reset in the middle of a pending move discards it.
    pulse_frame();
    rst = 1'b1; tick(1); rst = 1'b0;
    tick(4);
    check_eq("midrst_dxs", 32'(dxs), 32'd0);
    check_eq("midrst_dxe", 32'(dxe), 32'd0);
    check_eq("midrst_upd", 32'(update), 32'd0);

    // Frame divider of 2: moves on the 3rd and 6th frame only.
    frame_div = 4'd2; step_x = 4'd8;
    do_load(11'd100, 11'd100);
    tick(2);
    for (int f = 1; f <= 6; f++) begin
      base = upd_cnt;
      pulse_frame(); tick(5);
      check_eq($sformatf("div_frame%0d", f), 32'(upd_cnt - base), (f % 3 == 0) ? 32'd1 : 32'd0);
    end
    check_eq("div_dxs", 32'(dxs), 32'd116);

    // Overrun: back-to-back frame pulses give one move and a sticky flag.
    frame_div = 4'd0;
    base = upd_cnt;
    frame_start = 1'b1; tick(2); frame_start = 1'b0;
    tick(5);
    check_eq("ovr_single_move", 32'(upd_cnt - base), 32'd1);
    check_eq("ovr_dxs", 32'(dxs), 32'd124);
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    pulse_frame(); tick(5);
    check_eq("ovr_sticky", 32'(overrun), 32'd1);
    do_reset();
    check_eq("ovr_cleared", 32'(overrun), 32'd0);

    // Load colliding with a frame pulse; 700 clamps to 640-100.
    size_x = 11'd100;
    base = upd_cnt;
    init_x = 11'd700; init_y = 11'd10;
    load = 1'b1; frame_start = 1'b1;
    tick(1);
    load = 1'b0; frame_start = 1'b0;
    check_eq("col_upd", 32'(update), 32'd1);
    check_eq("col_dxs", 32'(dxs), 32'd540);
    check_eq("col_dxe", 32'(dxe), 32'd640);
    tick(6);
    check_eq("col_one_upd", 32'(upd_cnt - base), 32'd1);
    check_eq("col_overrun", 32'(overrun), 32'd0);
    check_eq("col_hold_dxs", 32'(dxs), 32'd540);

    // Oversize: width 700 pins to 0 with end at the edge, direction kept.
    size_x = 11'd700;
    pulse_frame(); tick(4);
    check_eq("ovs_dxs", 32'(dxs), 32'd0);
    check_eq("ovs_dxe", 32'(dxe), 32'd640);
    check_eq("ovs_dirx", 32'(dir_x), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
